// File: rtl/sbus_ahbl_manager_bridge_if.sv
// Bus bundles for the SBUS->AHB-Lite manager bridge: the SBUS request/response
// channel and the AHB-Lite manager port.

interface sbus_if;
    logic [31:0] sbus_addr;
    logic        sbus_write;
    logic [1:0]  sbus_size;
    logic        sbus_vld;
    logic [31:0] sbus_wdata;
    logic        sbus_rdy;
    logic        sbus_err;
    logic [31:0] sbus_rdata;

    modport master (
        output sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
        input  sbus_rdy, sbus_err, sbus_rdata
    );

    modport slave (
        input  sbus_addr, sbus_write, sbus_size, sbus_vld, sbus_wdata,
        output sbus_rdy, sbus_err, sbus_rdata
    );
endinterface

interface ahblm_if;
    logic [31:0] ahblm_haddr;
    logic        ahblm_hwrite;
    logic [1:0]  ahblm_htrans;
    logic [2:0]  ahblm_hsize;
    logic [2:0]  ahblm_hburst;
    logic [3:0]  ahblm_hprot;
    logic        ahblm_hmastlock;
    logic [31:0] ahblm_hwdata;
    logic        ahblm_hready;
    logic        ahblm_hresp;
    logic [31:0] ahblm_hrdata;

    modport master (
        output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
               ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
        input  ahblm_hready, ahblm_hresp, ahblm_hrdata
    );

    modport slave (
        input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
               ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
        output ahblm_hready, ahblm_hresp, ahblm_hrdata
    );
endinterface

// File: rtl/sbus_ahbl_manager_bridge.sv
// SBUS responder that replays each request as one AHB-Lite SINGLE transfer.
// Non-pipelined, one transfer outstanding, all outputs registered.
//
//   state  | meaning
//   IDLE   | waiting for sbus_vld; alignment check on request
//   ADDR   | NONSEQ address phase, held while !hready
//   DATA   | data phase, waiting for hready; capture response
//   RESP   | sbus_rdy pulse with error flag; vld ignored

module sbus_ahbl_manager_bridge #(
    parameter logic [3:0] HPROT_VAL   = 4'b0011,
    parameter bit         CHECK_ALIGN = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    sbus_if.slave    sbus,
    ahblm_if.master  ahblm
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_t state;
    logic   misaligned;

    assign misaligned = (sbus.sbus_size == 2'd3)
                      | ((sbus.sbus_size == 2'd1) & sbus.sbus_addr[0])
                      | ((sbus.sbus_size == 2'd2) & (sbus.sbus_addr[1:0] != 2'b00));

    assign ahblm.ahblm_hburst    = 3'b000;
    assign ahblm.ahblm_hprot     = HPROT_VAL;
    assign ahblm.ahblm_hmastlock = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            ahblm.ahblm_htrans <= HTRANS_IDLE;
            ahblm.ahblm_haddr  <= 32'h0;
            ahblm.ahblm_hwrite <= 1'b0;
            ahblm.ahblm_hsize  <= 3'b000;
            ahblm.ahblm_hwdata <= 32'h0;
            sbus.sbus_rdy      <= 1'b0;
            sbus.sbus_err      <= 1'b0;
            sbus.sbus_rdata    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sbus.sbus_rdy <= 1'b0;
                    sbus.sbus_err <= 1'b0;
                    if (sbus.sbus_vld) begin
                        ahblm.ahblm_haddr  <= sbus.sbus_addr;
                        ahblm.ahblm_hwrite <= sbus.sbus_write;
                        ahblm.ahblm_hsize  <= {1'b0, sbus.sbus_size};
                        // Rejected requests answer straight from IDLE so rdy lands one cycle after vld
                        if (CHECK_ALIGN && misaligned) begin
                            sbus.sbus_rdy <= 1'b1;
                            sbus.sbus_err <= 1'b1;
                            state         <= ST_RESP;
                        end else begin
                            ahblm.ahblm_htrans <= HTRANS_NONSEQ;
                            state              <= ST_ADDR;
                        end
                    end
                end
                ST_ADDR: begin
                    if (ahblm.ahblm_hready) begin
                        ahblm.ahblm_htrans <= HTRANS_IDLE;
                        ahblm.ahblm_hwdata <= sbus.sbus_wdata;
                        state              <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // First ERROR cycle has hready low and is simply waited out
                    if (ahblm.ahblm_hready) begin
                        sbus.sbus_rdy <= 1'b1;
                        sbus.sbus_err <= ahblm.ahblm_hresp;
                        if (!ahblm.ahblm_hresp && !ahblm.ahblm_hwrite)
                            sbus.sbus_rdata <= ahblm.ahblm_hrdata;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    sbus.sbus_rdy <= 1'b0;
                    sbus.sbus_err <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbus_ahbl_manager_bridge.sv
// Directed bench for sbus_ahbl_manager_bridge: latency, wait states, AHB and
// local errors, back-to-back requests and asynchronous reset.

module tb_sbus_ahbl_manager_bridge;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    sbus_if  sbus_bus ();
    ahblm_if ahb_bus ();

    sbus_ahbl_manager_bridge #(
        .HPROT_VAL   (4'b0011),
        .CHECK_ALIGN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sbus  (sbus_bus),
        .ahblm (ahb_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle boundary: 1 time unit after the active edge; inputs change and outputs are sampled here.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        sbus_bus.sbus_addr  = 32'h0;
        sbus_bus.sbus_write = 1'b0;
        sbus_bus.sbus_size  = 2'd0;
        sbus_bus.sbus_vld   = 1'b0;
        sbus_bus.sbus_wdata = 32'h0;
        ahb_bus.ahblm_hready = 1'b1;
        ahb_bus.ahblm_hresp  = 1'b0;
        ahb_bus.ahblm_hrdata = 32'h0;
        repeat (3) tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL reset_htrans: got %h want 0", ahb_bus.ahblm_htrans); end
        vectors++; if (ahb_bus.ahblm_haddr !== 32'h0) begin miscompares++; $display("FAIL reset_haddr: got %h want 0", ahb_bus.ahblm_haddr); end
        vectors++; if (ahb_bus.ahblm_hwrite !== 1'b0) begin miscompares++; $display("FAIL reset_hwrite: got %b want 0", ahb_bus.ahblm_hwrite); end
        vectors++; if (ahb_bus.ahblm_hsize !== 3'b000) begin miscompares++; $display("FAIL reset_hsize: got %h want 0", ahb_bus.ahblm_hsize); end
        vectors++; if (ahb_bus.ahblm_hwdata !== 32'h0) begin miscompares++; $display("FAIL reset_hwdata: got %h want 0", ahb_bus.ahblm_hwdata); end
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", sbus_bus.sbus_rdy); end
        vectors++; if (sbus_bus.sbus_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", sbus_bus.sbus_err); end
        vectors++; if (sbus_bus.sbus_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", sbus_bus.sbus_rdata); end
        vectors++; if (ahb_bus.ahblm_hburst !== 3'b000) begin miscompares++; $display("FAIL reset_hburst: got %h want 0", ahb_bus.ahblm_hburst); end
        vectors++; if (ahb_bus.ahblm_hprot !== 4'b0011) begin miscompares++; $display("FAIL reset_hprot: got %h want 3", ahb_bus.ahblm_hprot); end
        vectors++; if (ahb_bus.ahblm_hmastlock !== 1'b0) begin miscompares++; $display("FAIL reset_hmastlock: got %b want 0", ahb_bus.ahblm_hmastlock); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_word_read;
        sbus_bus.sbus_addr  = 32'h100;
        sbus_bus.sbus_write = 1'b0;
        sbus_bus.sbus_size  = 2'd2;
        ahb_bus.ahblm_hready = 1'b1;
        ahb_bus.ahblm_hresp  = 1'b0;
        ahb_bus.ahblm_hrdata = 32'hDEADBEEF;
        sbus_bus.sbus_vld = 1'b1;
        tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b10) begin miscompares++; $display("FAIL read_c1_htrans: got %h want 2", ahb_bus.ahblm_htrans); end
        vectors++; if (ahb_bus.ahblm_haddr !== 32'h100) begin miscompares++; $display("FAIL read_c1_haddr: got %h want 100", ahb_bus.ahblm_haddr); end
        vectors++; if (ahb_bus.ahblm_hsize !== 3'd2) begin miscompares++; $display("FAIL read_c1_hsize: got %h want 2", ahb_bus.ahblm_hsize); end
        vectors++; if (ahb_bus.ahblm_hwrite !== 1'b0) begin miscompares++; $display("FAIL read_c1_hwrite: got %b want 0", ahb_bus.ahblm_hwrite); end
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL read_c1_rdy: got %b want 0", sbus_bus.sbus_rdy); end
        tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL read_c2_htrans: got %h want 0", ahb_bus.ahblm_htrans); end
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL read_c2_rdy: got %b want 0", sbus_bus.sbus_rdy); end
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b1) begin miscompares++; $display("FAIL read_c3_rdy: got %b want 1", sbus_bus.sbus_rdy); end
        vectors++; if (sbus_bus.sbus_err !== 1'b0) begin miscompares++; $display("FAIL read_c3_err: got %b want 0", sbus_bus.sbus_err); end
        vectors++; if (sbus_bus.sbus_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_c3_rdata: got %h want deadbeef", sbus_bus.sbus_rdata); end
        sbus_bus.sbus_vld = 1'b0;
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL read_c4_rdy: got %b want 0", sbus_bus.sbus_rdy); end
        vectors++; if (sbus_bus.sbus_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_c4_rdata_hold: got %h want deadbeef", sbus_bus.sbus_rdata); end
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL read_c4_htrans: got %h want 0", ahb_bus.ahblm_htrans); end
    endtask

    task automatic test_byte_write_waits;
        // hready during cycles 0..7: two waits in the address phase, two in the data phase
        logic [7:0] hready_seq;
        logic [1:0] exp_htrans;
        hready_seq = 8'b1100_1000;
        sbus_bus.sbus_addr  = 32'h203;
        sbus_bus.sbus_write = 1'b1;
        sbus_bus.sbus_size  = 2'd0;
        sbus_bus.sbus_wdata = 32'h0;
        ahb_bus.ahblm_hrdata = 32'h77777777;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            exp_htrans = (c >= 1 && c <= 3) ? 2'b10 : 2'b00;
            vectors++; if (ahb_bus.ahblm_htrans !== exp_htrans) begin miscompares++; $display("FAIL wr_c%0d_htrans: got %h want %h", c, ahb_bus.ahblm_htrans, exp_htrans); end
            vectors++; if (sbus_bus.sbus_rdy !== (c == 7)) begin miscompares++; $display("FAIL wr_c%0d_rdy: got %b want %b", c, sbus_bus.sbus_rdy, (c == 7)); end
            if (c >= 1 && c <= 3) begin
                vectors++; if (ahb_bus.ahblm_haddr !== 32'h203) begin miscompares++; $display("FAIL wr_c%0d_haddr: got %h want 203", c, ahb_bus.ahblm_haddr); end
                vectors++; if (ahb_bus.ahblm_hsize !== 3'd0) begin miscompares++; $display("FAIL wr_c%0d_hsize: got %h want 0", c, ahb_bus.ahblm_hsize); end
                vectors++; if (ahb_bus.ahblm_hwrite !== 1'b1) begin miscompares++; $display("FAIL wr_c%0d_hwrite: got %b want 1", c, ahb_bus.ahblm_hwrite); end
            end
            if (c >= 4 && c <= 6) begin
                vectors++; if (ahb_bus.ahblm_hwdata !== 32'h5A000000) begin miscompares++; $display("FAIL wr_c%0d_hwdata: got %h want 5a000000", c, ahb_bus.ahblm_hwdata); end
            end
            if (c == 7) begin
                vectors++; if (sbus_bus.sbus_err !== 1'b0) begin miscompares++; $display("FAIL wr_c7_err: got %b want 0", sbus_bus.sbus_err); end
                vectors++; if (sbus_bus.sbus_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr_c7_rdata_hold: got %h want deadbeef", sbus_bus.sbus_rdata); end
            end
            ahb_bus.ahblm_hready = hready_seq[c];
            if (c == 0) sbus_bus.sbus_vld = 1'b1;
            if (c == 1) sbus_bus.sbus_wdata = 32'h5A000000;
            if (c == 7) sbus_bus.sbus_vld = 1'b0;
        end
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL wr_c8_rdy: got %b want 0", sbus_bus.sbus_rdy); end
    endtask

    task automatic test_ahb_error;
        sbus_bus.sbus_addr  = 32'h400;
        sbus_bus.sbus_write = 1'b0;
        sbus_bus.sbus_size  = 2'd2;
        ahb_bus.ahblm_hready = 1'b1;
        ahb_bus.ahblm_hresp  = 1'b0;
        ahb_bus.ahblm_hrdata = 32'h11111111;
        sbus_bus.sbus_vld = 1'b1;
        tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b10) begin miscompares++; $display("FAIL err_c1_htrans: got %h want 2", ahb_bus.ahblm_htrans); end
        tick();
        ahb_bus.ahblm_hready = 1'b0;
        ahb_bus.ahblm_hresp  = 1'b1;
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL err_c3_rdy: got %b want 0", sbus_bus.sbus_rdy); end
        ahb_bus.ahblm_hready = 1'b1;
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b1) begin miscompares++; $display("FAIL err_c4_rdy: got %b want 1", sbus_bus.sbus_rdy); end
        vectors++; if (sbus_bus.sbus_err !== 1'b1) begin miscompares++; $display("FAIL err_c4_err: got %b want 1", sbus_bus.sbus_err); end
        vectors++; if (sbus_bus.sbus_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL err_c4_rdata: got %h want deadbeef", sbus_bus.sbus_rdata); end
        sbus_bus.sbus_vld = 1'b0;
        ahb_bus.ahblm_hresp = 1'b0;
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL err_c5_rdy: got %b want 0", sbus_bus.sbus_rdy); end
        vectors++; if (sbus_bus.sbus_err !== 1'b0) begin miscompares++; $display("FAIL err_c5_err: got %b want 0", sbus_bus.sbus_err); end
    endtask

    task automatic test_local_error;
        logic [31:0] addrs [2];
        logic [1:0]  sizes [2];
        addrs[0] = 32'h301; sizes[0] = 2'd1;
        addrs[1] = 32'h0;   sizes[1] = 2'd3;
        ahb_bus.ahblm_hready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sbus_bus.sbus_addr  = addrs[i];
            sbus_bus.sbus_size  = sizes[i];
            sbus_bus.sbus_write = 1'b0;
            sbus_bus.sbus_vld   = 1'b1;
            tick();
            vectors++; if (sbus_bus.sbus_rdy !== 1'b1) begin miscompares++; $display("FAIL local%0d_c1_rdy: got %b want 1", i, sbus_bus.sbus_rdy); end
            vectors++; if (sbus_bus.sbus_err !== 1'b1) begin miscompares++; $display("FAIL local%0d_c1_err: got %b want 1", i, sbus_bus.sbus_err); end
            vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL local%0d_c1_htrans: got %h want 0", i, ahb_bus.ahblm_htrans); end
            sbus_bus.sbus_vld = 1'b0;
            tick();
            vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL local%0d_c2_rdy: got %b want 0", i, sbus_bus.sbus_rdy); end
            vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL local%0d_c2_htrans: got %h want 0", i, ahb_bus.ahblm_htrans); end
        end
    endtask

    task automatic test_back_to_back;
        int nonseq_cnt;
        int rdy_cnt;
        int nonseq_cyc [4];
        int rdy_cyc [4];
        nonseq_cnt = 0;
        rdy_cnt = 0;
        for (int k = 0; k < 4; k++) begin nonseq_cyc[k] = -1; rdy_cyc[k] = -1; end
        sbus_bus.sbus_addr  = 32'h500;
        sbus_bus.sbus_write = 1'b0;
        sbus_bus.sbus_size  = 2'd2;
        ahb_bus.ahblm_hready = 1'b1;
        ahb_bus.ahblm_hresp  = 1'b0;
        ahb_bus.ahblm_hrdata = 32'hCAFEF00D;
        sbus_bus.sbus_vld = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ahb_bus.ahblm_htrans === 2'b10) begin
                if (nonseq_cnt < 4) nonseq_cyc[nonseq_cnt] = c;
                nonseq_cnt++;
            end
            if (sbus_bus.sbus_rdy === 1'b1) begin
                if (rdy_cnt < 4) rdy_cyc[rdy_cnt] = c;
                rdy_cnt++;
                if (rdy_cnt == 2) sbus_bus.sbus_vld = 1'b0;
            end
        end
        vectors++; if (nonseq_cnt !== 2) begin miscompares++; $display("FAIL b2b_nonseq_count: got %0d want 2", nonseq_cnt); end
        vectors++; if (rdy_cnt !== 2) begin miscompares++; $display("FAIL b2b_rdy_count: got %0d want 2", rdy_cnt); end
        // Second request is sampled in the cycle after rdy; three idle bus cycles separate the NONSEQs
        vectors++; if (nonseq_cyc[0] !== 1) begin miscompares++; $display("FAIL b2b_nonseq0_cycle: got %0d want 1", nonseq_cyc[0]); end
        vectors++; if (nonseq_cyc[1] !== 5) begin miscompares++; $display("FAIL b2b_nonseq1_cycle: got %0d want 5", nonseq_cyc[1]); end
        vectors++; if (rdy_cyc[0] !== 3) begin miscompares++; $display("FAIL b2b_rdy0_cycle: got %0d want 3", rdy_cyc[0]); end
        vectors++; if (rdy_cyc[1] !== 7) begin miscompares++; $display("FAIL b2b_rdy1_cycle: got %0d want 7", rdy_cyc[1]); end
        vectors++; if (sbus_bus.sbus_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL b2b_rdata: got %h want cafef00d", sbus_bus.sbus_rdata); end
    endtask

    task automatic test_reset_mid_transfer;
        sbus_bus.sbus_addr  = 32'h600;
        sbus_bus.sbus_write = 1'b1;
        sbus_bus.sbus_size  = 2'd2;
        sbus_bus.sbus_wdata = 32'h12345678;
        ahb_bus.ahblm_hready = 1'b0;
        sbus_bus.sbus_vld = 1'b1;
        tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b10) begin miscompares++; $display("FAIL rstmid_c1_htrans: got %h want 2", ahb_bus.ahblm_htrans); end
        tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b10) begin miscompares++; $display("FAIL rstmid_c2_htrans: got %h want 2", ahb_bus.ahblm_htrans); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL rstmid_async_htrans: got %h want 0", ahb_bus.ahblm_htrans); end
        vectors++; if (ahb_bus.ahblm_haddr !== 32'h0) begin miscompares++; $display("FAIL rstmid_async_haddr: got %h want 0", ahb_bus.ahblm_haddr); end
        sbus_bus.sbus_vld = 1'b0;
        ahb_bus.ahblm_hready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            vectors++; if (sbus_bus.sbus_rdy !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle%0d_rdy: got %b want 0", c, sbus_bus.sbus_rdy); end
            vectors++; if (ahb_bus.ahblm_htrans !== 2'b00) begin miscompares++; $display("FAIL rstmid_idle%0d_htrans: got %h want 0", c, ahb_bus.ahblm_htrans); end
        end
        sbus_bus.sbus_addr  = 32'h104;
        sbus_bus.sbus_write = 1'b0;
        ahb_bus.ahblm_hrdata = 32'hA5A5A5A5;
        sbus_bus.sbus_vld = 1'b1;
        tick();
        vectors++; if (ahb_bus.ahblm_htrans !== 2'b10) begin miscompares++; $display("FAIL rstmid_new_c1_htrans: got %h want 2", ahb_bus.ahblm_htrans); end
        vectors++; if (ahb_bus.ahblm_haddr !== 32'h104) begin miscompares++; $display("FAIL rstmid_new_c1_haddr: got %h want 104", ahb_bus.ahblm_haddr); end
        tick();
        tick();
        vectors++; if (sbus_bus.sbus_rdy !== 1'b1) begin miscompares++; $display("FAIL rstmid_new_c3_rdy: got %b want 1", sbus_bus.sbus_rdy); end
        vectors++; if (sbus_bus.sbus_rdata !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL rstmid_new_c3_rdata: got %h want a5a5a5a5", sbus_bus.sbus_rdata); end
        sbus_bus.sbus_vld = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_byte_write_waits();
        test_ahb_error();
        test_local_error();
        test_back_to_back();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
